// File: rtl/spi_pwm_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_pwm_multi
// Brief    : Write-only mode-0 SPI slave driving NUM_CH PWM channels that share
//            one prescaled period counter. Optional macro PWM_SHADOW_EN makes
//            duty writes take effect only at the period wrap.
// Revision : 1.0 - initial release
// ============================================================================
module spi_pwm_multi #(
  parameter int NUM_CH  = 16,
  parameter int DUTY_W  = 8,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nCS,
  input  logic              SCLK,
  input  logic              COPI,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] out_en,
  output logic              frame_err
);

  localparam logic [4:0] c_frame_len  = 5'd16;
  localparam logic [4:0] c_cnt_sat    = 5'd17;
  localparam logic [6:0] c_addr_presc = 7'h08;

  logic [2:0]         ncs_pipe_q, ncs_pipe_d;
  logic [2:0]         sclk_pipe_q, sclk_pipe_d;
  logic [1:0]         copi_pipe_q, copi_pipe_d;
  logic               in_frame_q, in_frame_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [15:0]        shift_q, shift_d;
  logic               wr_q, wr_d;
  logic [6:0]         wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               frame_err_q, frame_err_d;
  logic [NUM_CH-1:0]  en_out_q, en_out_d;
  logic [NUM_CH-1:0]  en_pwm_q, en_pwm_d;
  logic [PRESC_W-1:0] prescale_q, prescale_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [DUTY_W-1:0]  period_cnt_q, period_cnt_d;
  logic [NUM_CH-1:0]  en_out_hit, en_pwm_hit, wr_bit;
  logic               ncs_fall, ncs_rise, sclk_rise;
  logic               presc_wr, tick, period_wrap;

  assign ncs_fall  =  ncs_pipe_q[2] & ~ncs_pipe_q[1];
  assign ncs_rise  = ~ncs_pipe_q[2] &  ncs_pipe_q[1];
  assign sclk_rise = ~sclk_pipe_q[2] & sclk_pipe_q[1];

  // A rising nCS only counts when a falling edge opened the frame, so a reset
  // taken mid-frame cannot later produce a commit or an error.
  always_comb begin
    ncs_pipe_d  = {ncs_pipe_q[1:0], nCS};
    sclk_pipe_d = {sclk_pipe_q[1:0], SCLK};
    copi_pipe_d = {copi_pipe_q[0], COPI};
    in_frame_d  = in_frame_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wr_d        = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    if (ncs_fall) begin
      in_frame_d = 1'b1;
      bit_cnt_d  = 5'd0;
    end else if (ncs_rise) begin
      in_frame_d = 1'b0;
      if (in_frame_q) begin
        if (bit_cnt_q == c_frame_len) begin
          if (shift_q[15]) begin
            wr_d      = 1'b1;
            wr_addr_d = shift_q[14:8];
            wr_data_d = shift_q[7:0];
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end else if (sclk_rise && !ncs_pipe_q[1] && in_frame_q) begin
      shift_d = {shift_q[14:0], copi_pipe_q[1]};
      if (bit_cnt_q != c_cnt_sat) bit_cnt_d = bit_cnt_q + 5'd1;
    end
  end

  always_comb begin
    presc_wr     = wr_q && (wr_addr_q == c_addr_presc);
    en_out_d     = wr_q ? ((en_out_q & ~en_out_hit) | (wr_bit & en_out_hit)) : en_out_q;
    en_pwm_d     = wr_q ? ((en_pwm_q & ~en_pwm_hit) | (wr_bit & en_pwm_hit)) : en_pwm_q;
    prescale_d   = presc_wr ? PRESC_W'(wr_data_q) : prescale_q;
    tick         = (presc_cnt_q == prescale_q);
    presc_cnt_d  = (presc_wr || tick) ? '0 : presc_cnt_q + PRESC_W'(1);
    period_cnt_d = tick ? period_cnt_q + DUTY_W'(1) : period_cnt_q;
    period_wrap  = tick && (&period_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_pipe_q   <= '0;
      sclk_pipe_q  <= '0;
      copi_pipe_q  <= '0;
      in_frame_q   <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      wr_q         <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_err_q  <= 1'b0;
      en_out_q     <= '0;
      en_pwm_q     <= '0;
      prescale_q   <= '0;
      presc_cnt_q  <= '0;
      period_cnt_q <= '0;
    end else begin
      ncs_pipe_q   <= ncs_pipe_d;
      sclk_pipe_q  <= sclk_pipe_d;
      copi_pipe_q  <= copi_pipe_d;
      in_frame_q   <= in_frame_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      wr_q         <= wr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_err_q  <= frame_err_d;
      en_out_q     <= en_out_d;
      en_pwm_q     <= en_pwm_d;
      prescale_q   <= prescale_d;
      presc_cnt_q  <= presc_cnt_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DUTY_W-1:0] duty_q, duty_d, duty_act;
    logic              pwm_q, pwm_d, raw;

    assign en_out_hit[i] = (wr_addr_q == 7'(i / 8));
    assign en_pwm_hit[i] = (wr_addr_q == 7'(4 + i / 8));
    assign wr_bit[i]     = wr_data_q[i % 8];

`ifdef PWM_SHADOW_EN
    logic [DUTY_W-1:0] duty_act_q, duty_act_d;
    assign duty_act   = duty_act_q;
    assign duty_act_d = period_wrap ? duty_q : duty_act_q;
    always_ff @(posedge clk) begin
      if (rst) duty_act_q <= '0;
      else     duty_act_q <= duty_act_d;
    end
`else
    assign duty_act = duty_q;
`endif

    // All-ones duty is a full-period high rather than 2^DUTY_W-1 cycles.
    always_comb begin
      duty_d = duty_q;
      if (wr_q && (wr_addr_q == 7'(16 + i))) duty_d = DUTY_W'(wr_data_q);
      raw   = (period_cnt_q < duty_act) || (&duty_act);
      pwm_d = en_out_q[i] ? (en_pwm_q[i] ? raw : 1'b1) : 1'b0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        duty_q <= '0;
        pwm_q  <= 1'b0;
      end else begin
        duty_q <= duty_d;
        pwm_q  <= pwm_d;
      end
    end

    assign pwm_out[i] = pwm_q;
  end

  assign out_en    = en_out_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_pwm_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_pwm_multi
// Brief    : Directed scoreboard bench for spi_pwm_multi (honours PWM_SHADOW_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_pwm_multi;
  localparam int NUM_CH = 16;
  localparam logic [2:0] K_PWM = 3'd0, K_OEN = 3'd1, K_FERR = 3'd2,
                         K_HIGH = 3'd3, K_FLAG = 3'd4, K_FPIN = 3'd5;

  logic clk = 1'b0, rst = 1'b1, ncs = 1'b1, sclk = 1'b0, copi = 1'b0;
  logic [NUM_CH-1:0] pwm_out, out_en;
  logic frame_err;
  int checks = 0, errors = 0, ferr_cnt = 0;
  int hi0, hi1, e0;
  bit found;

  typedef struct packed {logic [2:0] kind; logic [31:0] val;} exp_t;
  exp_t exp_q[$];

  spi_pwm_multi #(.NUM_CH(NUM_CH), .DUTY_W(8), .PRESC_W(8)) dut (
    .clk(clk), .rst(rst), .nCS(ncs), .SCLK(sclk), .COPI(copi),
    .pwm_out(pwm_out), .out_en(out_en), .frame_err(frame_err));

  always #5 clk = ~clk;
  always @(posedge clk) if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;

  function automatic string kind_name(input logic [2:0] k);
    case (k)
      K_PWM:   return "pwm_out";
      K_OEN:   return "out_en";
      K_FERR:  return "frame_err_count";
      K_HIGH:  return "high_cycles";
      K_FLAG:  return "condition";
      default: return "frame_err_pin";
    endcase
  endfunction

  task automatic push(input logic [2:0] kind, input logic [31:0] val);
    exp_q.push_back('{kind: kind, val: val});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", kind_name(e.kind), obs, e.val);
      end
    end
  endtask

  task automatic spi_bits(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = v << (32 - n);
    for (int b = 0; b < n; b++) begin
      copi = t[31];
      t = t << 1;
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] v, input int n);
    ncs = 1'b0;
    #40;
    spi_bits(v, n);
    #40 ncs = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    spi_frame({16'h0000, 1'b1, addr, data}, 16);
  endtask

  task automatic count_high(input logic [NUM_CH-1:0] sel, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if ((pwm_out & sel) != '0) hi++;
    end
  endtask

  task automatic wait_rise(input logic [NUM_CH-1:0] sel, output bit ok);
    bit prev, cur;
    ok = 1'b0;
    prev = 1'b1;
    for (int k = 0; k < 4096; k++) begin
      @(negedge clk);
      cur = ((pwm_out & sel) != '0);
      if (cur && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = cur;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    push(K_PWM, 0);  check(32'(pwm_out));
    push(K_OEN, 0);  check(32'(out_en));
    push(K_FPIN, 0); check(32'(frame_err));

    // Output enable only: channels 0..7 forced high
    spi_write(7'h00, 8'hFF);
    spi_write(7'h04, 8'h00);
    @(negedge clk);
    push(K_PWM, 32'h00FF); check(32'(pwm_out));
    push(K_OEN, 32'h00FF); check(32'(out_en));

    // Channel 0 PWM, prescale 0: 256-cycle period
    spi_write(7'h00, 8'h01);
    spi_write(7'h04, 8'h01);
    spi_write(7'h08, 8'h00);
    spi_write(7'h10, 8'h80);
    count_high(16'h0001, 256, hi0); push(K_HIGH, 128); check(32'(hi0));
    spi_write(7'h10, 8'h00);
    count_high(16'h0001, 256, hi0); push(K_HIGH, 0);   check(32'(hi0));
    spi_write(7'h10, 8'hFF);
    count_high(16'h0001, 256, hi0); push(K_HIGH, 256); check(32'(hi0));

    // Prescale 3, channel 1 duty 0x40: 1024-cycle period, 256 high
    spi_write(7'h00, 8'h03);
    spi_write(7'h04, 8'h03);
    spi_write(7'h08, 8'h03);
    spi_write(7'h11, 8'h40);
    count_high(16'h0002, 1024, hi1); push(K_HIGH, 256); check(32'(hi1));

    // Malformed frames: short, long, and a read
    e0 = ferr_cnt;
    spi_frame(32'h0000_4000, 15);
    push(K_FERR, 32'(e0 + 1)); check(32'(ferr_cnt));
    push(K_OEN, 32'h0003);     check(32'(out_en));
    spi_frame(32'h0000_8000, 17);
    push(K_FERR, 32'(e0 + 2)); check(32'(ferr_cnt));
    push(K_OEN, 32'h0003);     check(32'(out_en));
    spi_frame(32'h0000_0000, 16);
    push(K_FERR, 32'(e0 + 2)); check(32'(ferr_cnt));
    push(K_OEN, 32'h0003);     check(32'(out_en));

    // Writes beyond NUM_CH and to an unmapped address
    spi_write(7'(16 + NUM_CH), 8'h00);
    spi_write(7'h09, 8'h00);
    push(K_OEN, 32'h0003); check(32'(out_en));
    count_high(16'h0001, 1024, hi0); push(K_HIGH, 1024); check(32'(hi0));
    count_high(16'h0002, 1024, hi1); push(K_HIGH, 256);  check(32'(hi1));

    // Reset after 8 bits of a write frame
    e0 = ferr_cnt;
    ncs = 1'b0;
    #40;
    spi_bits(32'h0000_0080, 8);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    push(K_PWM, 0); check(32'(pwm_out));
    push(K_OEN, 0); check(32'(out_en));
    @(negedge clk) rst = 1'b0;
    spi_bits(32'h0000_00FF, 8);
    #40 ncs = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    push(K_OEN, 0);           check(32'(out_en));
    push(K_FERR, 32'(e0));    check(32'(ferr_cnt));

    // Duty change from 0x80 to 0x20 early in a 1024-cycle period
    spi_write(7'h00, 8'h01);
    spi_write(7'h04, 8'h01);
    spi_write(7'h08, 8'h03);
    spi_write(7'h10, 8'h80);
    wait_rise(16'h0001, found);
    push(K_FLAG, 1); check(32'(found));
    fork
      begin
        count_high(16'h0001, 1023, hi0);
        hi0 = hi0 + 1;
      end
      spi_write(7'h10, 8'h20);
    join
`ifdef PWM_SHADOW_EN
    push(K_HIGH, 512); check(32'(hi0));
`else
    push(K_FLAG, 1); check(32'(hi0 > 0 && hi0 < 512));
`endif
    count_high(16'h0001, 1024, hi0); push(K_HIGH, 128); check(32'(hi0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
